ofdm_fft_sequencer: RTL
=======================

OFDM_FFT_SEQUENCER -- requirements
Module: ofdm_fft_sequencer

Interface
REQ-001 SHALL have parameter N, default 16, sample width in bits (two's complement, Q8 fixed point as in the FFT datapath).
REQ-002 SHALL have parameter DONE_SKIP, default 2, number of FFT cycle-done pulses to wait after a load before results are declared valid (range 1..7).
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for DONE_SKIP pulses (range 1..255).
REQ-004 SHALL use a single clock and asynchronous active-low reset: i_clk  in  1  clock, rising edge; i_rst  in  1  asynchronous active-low reset.
REQ-005 i_s_valid  in  1  input subcarrier sample valid.
REQ-006 o_s_ready  out  1  sequencer can accept a sample.
REQ-007 i_s_re / i_s_im  in  N each  subcarrier sample real/imag.
REQ-008 o_sc_re / o_sc_im  out  4*N each  held FFT subcarrier inputs; slot k at bits [k*N +: N] (slot0..3 = FFT inputs 0,1,3,7).
REQ-009 i_fft_done  in  1  one-cycle FFT cycle-done pulse.
REQ-010 o_sym_valid  out  1  FFT outputs belong to the current loaded symbol.
REQ-011 i_sym_ready  in  1  consumer accepts the symbol.
REQ-012 o_sym_cnt  out  8  count of symbols handed off.
REQ-013 o_busy  out  1  high in WAIT and PRESENT.
REQ-014 o_timeout_err  out  1  sticky timeout flag.

Function
REQ-015 SHALL implement FSM LOAD -> WAIT -> PRESENT -> LOAD; state encoding is free.
REQ-016 LOAD: o_s_ready=1; each cycle with i_s_valid=1 SHALL write the sample to slot[slot_cnt] and increment the 2-bit slot_cnt.
REQ-017 Accepting the sample into slot 3 at cycle T SHALL enter WAIT at T+1, with slot_cnt wrapping to 0.
REQ-018 WAIT: o_s_ready=0; SHALL count i_fft_done pulses sampled from T+1 onward; on the cycle the count reaches DONE_SKIP, SHALL enter PRESENT next cycle.
REQ-019 WAIT: SHALL count cycles; if DONE_SKIP is not reached by cycle count TIMEOUT, SHALL set o_timeout_err=1 and return to LOAD.
REQ-020 A done pulse that completes DONE_SKIP on the timeout cycle SHALL win: enter PRESENT, no error.
REQ-021 PRESENT: o_sym_valid=1, held until i_sym_ready=1; on handshake SHALL increment o_sym_cnt (255 wraps to 0) and enter LOAD next cycle.
REQ-022 i_fft_done in LOAD or PRESENT SHALL be ignored; i_sym_ready outside PRESENT SHALL be ignored.
REQ-023 o_sc_re/o_sc_im SHALL change only on an accepted LOAD write and hold in WAIT/PRESENT; a timed-out symbol's slots SHALL be retained until overwritten.
REQ-024 o_s_ready, o_sym_valid and o_busy SHALL be decoded from registered state only, with no combinational path from any input.
REQ-025 o_timeout_err SHALL be cleared only by reset.

Reset
REQ-026 i_rst=0 SHALL asynchronously force state LOAD, slot_cnt=0, all slots=0, done/cycle counters=0, o_sym_cnt=0, o_timeout_err=0; hence o_s_ready=1, o_sym_valid=0, o_busy=0.
REQ-027 Reset asserted mid-WAIT or mid-PRESENT SHALL abandon the symbol without incrementing o_sym_cnt; reset release SHALL take effect synchronously on the next rising edge.

Verification
REQ-028 Load re=1,2,3,4 (im=0) on 4 consecutive cycles, then pulse done twice -> o_sc_re slots = 1,2,3,4; o_sym_valid rises the cycle after the 2nd pulse; i_sym_ready=1 -> o_sym_cnt=1, back in LOAD.
REQ-029 Done pulse on the same cycle as the 4th sample accept -> not counted; 2 further pulses required before o_sym_valid=1.
REQ-030 Load a symbol, send no done pulses -> after 255 WAIT cycles o_timeout_err=1 and o_s_ready=1; the flag stays 1 across the next good symbol.
REQ-031 2nd done pulse on WAIT cycle 255 -> PRESENT, o_timeout_err=0.
REQ-032 Hold i_sym_ready=0 for 10 cycles in PRESENT -> o_sym_valid stays 1 and o_sc unchanged; 256 handshaken symbols -> o_sym_cnt=0.
REQ-033 Reset pulsed in WAIT after 1 done pulse -> all outputs at reset values immediately; after release a fresh 4-sample load is required.

Source files
------------

// File: rtl/ofdm_fft_sequencer.sv
// rtl/ofdm_fft_sequencer.sv - collects four subcarrier samples, waits for FFT done pulses, presents the symbol
module ofdm_fft_sequencer #(
  parameter int N         = 16,
  parameter int DONE_SKIP = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  input  logic [N-1:0]     i_s_re,
  input  logic [N-1:0]     i_s_im,
  output logic [4*N-1:0]   o_sc_re,
  output logic [4*N-1:0]   o_sc_im,
  input  logic             i_fft_done,
  output logic             o_sym_valid,
  input  logic             i_sym_ready,
  output logic [7:0]       o_sym_cnt,
  output logic             o_busy,
  output logic             o_timeout_err
);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_WAIT    = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  localparam logic [3:0] SKIP = 4'(DONE_SKIP);
  localparam logic [8:0] TMO  = 9'(TIMEOUT);

  state_t     state;
  logic [1:0] slot_cnt;
  logic [2:0] done_cnt;
  logic [7:0] cyc_cnt;

  // done_sum / cyc_sum are the counts including the current WAIT cycle
  logic [3:0] done_sum;
  logic [8:0] cyc_sum;
  assign done_sum = {1'b0, done_cnt} + {3'b000, i_fft_done};
  assign cyc_sum  = {1'b0, cyc_cnt} + 9'd1;

  // handshake outputs come straight from the state register
  assign o_s_ready   = (state == S_LOAD);
  assign o_sym_valid = (state == S_PRESENT);
  assign o_busy      = (state == S_WAIT) || (state == S_PRESENT);

  // sequencer FSM, slot capture, counters and sticky timeout flag
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= S_LOAD;
      slot_cnt      <= 2'd0;
      done_cnt      <= 3'd0;
      cyc_cnt       <= 8'd0;
      o_sc_re       <= '0;
      o_sc_im       <= '0;
      o_sym_cnt     <= 8'd0;
      o_timeout_err <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (i_s_valid) begin
            o_sc_re[slot_cnt*N +: N] <= i_s_re;
            o_sc_im[slot_cnt*N +: N] <= i_s_im;
            slot_cnt                 <= slot_cnt + 2'd1;
            if (slot_cnt == 2'd3) begin
              // done pulses coincident with the last accept are not counted
              state    <= S_WAIT;
              done_cnt <= 3'd0;
              cyc_cnt  <= 8'd0;
            end
          end
        end
        S_WAIT: begin
          // a completing done pulse beats the timeout on the same cycle
          if (done_sum == SKIP) begin
            state <= S_PRESENT;
          end else if (cyc_sum == TMO) begin
            state         <= S_LOAD;
            o_timeout_err <= 1'b1;
          end else begin
            done_cnt <= done_sum[2:0];
            cyc_cnt  <= cyc_sum[7:0];
          end
        end
        S_PRESENT: begin
          if (i_sym_ready) begin
            state     <= S_LOAD;
            o_sym_cnt <= o_sym_cnt + 8'd1;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
